// File: rtl/color_pkg.sv
// Shared colour codes and frame-tally state encoding used by color_detection
// and the dominant-colour tally.
package color_pkg;

  localparam logic [1:0] COLOR_NONE  = 2'd0;
  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_BLUE  = 2'd3;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DECIDE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // One-hot LED pattern {red, green, blue} for a colour code; none gives all off.
  function automatic logic [2:0] color_leds(input logic [1:0] color);
    logic [2:0] leds;
    leds = 3'b000;
    case (color)
      COLOR_RED:   leds = 3'b100;
      COLOR_GREEN: leds = 3'b010;
      COLOR_BLUE:  leds = 3'b001;
      default:     leds = 3'b000;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/dominant_color_tally_select.sv
// Combinational 3-way strict-maximum compare with a minimum-count floor.
// A colour wins only when it strictly beats both others and reaches MIN_COUNT.
module dominant_select
  import color_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MIN_COUNT = 1
) (
  input  logic [CNT_W-1:0] red_cnt_i,
  input  logic [CNT_W-1:0] green_cnt_i,
  input  logic [CNT_W-1:0] blue_cnt_i,
  output logic [1:0]       color_o
);

  // A floor above the counter range can never be met.
  localparam bit              FLOOR_UNREACHABLE = (longint'(MIN_COUNT) >= (longint'(1) << CNT_W));
  localparam logic [CNT_W-1:0] MIN_C            = CNT_W'(MIN_COUNT);

  logic red_wins;
  logic green_wins;
  logic blue_wins;

  // Strict-max test per colour; any tie leaves every colour losing.
  always_comb begin
    red_wins   = (red_cnt_i > green_cnt_i) && (red_cnt_i > blue_cnt_i)
                 && (red_cnt_i >= MIN_C) && !FLOOR_UNREACHABLE;
    green_wins = (green_cnt_i > red_cnt_i) && (green_cnt_i > blue_cnt_i)
                 && (green_cnt_i >= MIN_C) && !FLOOR_UNREACHABLE;
    blue_wins  = (blue_cnt_i > red_cnt_i) && (blue_cnt_i > green_cnt_i)
                 && (blue_cnt_i >= MIN_C) && !FLOOR_UNREACHABLE;
  end

  // At most one of the win flags can be set, so the priority order is irrelevant.
  always_comb begin
    color_o = COLOR_NONE;
    if (red_wins) begin
      color_o = COLOR_RED;
    end else if (green_wins) begin
      color_o = COLOR_GREEN;
    end else if (blue_wins) begin
      color_o = COLOR_BLUE;
    end
  end

endmodule

// File: rtl/dominant_color_tally.sv
// Framed, restartable tally of per-pixel red/green/blue detection flags.
// Counts each colour over PIXELS_PER_FRAME accepted pixels, decides the
// dominant colour once per frame and holds it on a valid/ready output,
// mirrored onto one-hot LED outputs.
module dominant_color_tally
  import color_pkg::*;
#(
  parameter int unsigned PIXELS_PER_FRAME = 256,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned MIN_COUNT        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_red,
  input  logic             in_green,
  input  logic             in_blue,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_color,
  output logic [CNT_W-1:0] out_red_cnt,
  output logic [CNT_W-1:0] out_green_cnt,
  output logic [CNT_W-1:0] out_blue_cnt,
  output logic             red_led,
  output logic             green_led,
  output logic             blue_led
);

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(PIXELS_PER_FRAME);

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] red_q, green_q, blue_q, pix_q;
  logic [CNT_W-1:0] red_d, green_d, blue_d, pix_d;
  logic             out_valid_q;
  logic [1:0]       out_color_q;
  logic [CNT_W-1:0] out_red_q, out_green_q, out_blue_q;
  logic [2:0]       leds_q;
  logic [1:0]       winner;
  logic             accept;

  // Ready depends on the state register only; it is also held low during reset.
  assign in_ready = rst_n && (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  // Counter update for an accepted pixel; a start-of-frame pixel restarts from zero.
  always_comb begin
    red_d   = sat_inc(in_sof ? '0 : red_q,   in_red);
    green_d = sat_inc(in_sof ? '0 : green_q, in_green);
    blue_d  = sat_inc(in_sof ? '0 : blue_q,  in_blue);
    pix_d   = sat_inc(in_sof ? '0 : pix_q,   1'b1);
  end

  dominant_select #(
    .CNT_W     (CNT_W),
    .MIN_COUNT (MIN_COUNT)
  ) u_select (
    .red_cnt_i   (red_q),
    .green_cnt_i (green_q),
    .blue_cnt_i  (blue_q),
    .color_o     (winner)
  );

  // Frame FSM: accumulate pixels, decide once, hold the result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      pix_q       <= '0;
      out_valid_q <= 1'b0;
      out_color_q <= COLOR_NONE;
      out_red_q   <= '0;
      out_green_q <= '0;
      out_blue_q  <= '0;
      leds_q      <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            pix_q   <= pix_d;
            if (pix_d == FRAME_LEN) begin
              state_q <= DECIDE;
            end
          end
        end
        DECIDE: begin
          out_color_q <= winner;
          out_red_q   <= red_q;
          out_green_q <= green_q;
          out_blue_q  <= blue_q;
          leds_q      <= color_leds(winner);
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            pix_q       <= '0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_color     = out_color_q;
  assign out_red_cnt   = out_red_q;
  assign out_green_cnt = out_green_q;
  assign out_blue_cnt  = out_blue_q;
  assign red_led       = leds_q[2];
  assign green_led     = leds_q[1];
  assign blue_led      = leds_q[0];

endmodule
